day10_machine_reader: RTL and testbench
=======================================

// Module: day10_machine_reader
// PURPOSE
//  Parses one day-10 machine record per transaction from an AXI-stream byte/word feed into
//  registered fields: light count, target mask, button count, button masks, optional joltages.
//  Runs continuously after reset, with no start pulse. Each finished record is held on a
//  valid/ready output port until the solver core consumes it.
//  Sits between the input DMA/stream source and the day-10 solver.
// PARAMETERS
//  MAX_NUM_LIGHTS    16  max lights per machine; sizes every mask
//  MAX_NUM_BUTTONS   16  max buttons per machine; depth of button array
//  AXI_DATA_WIDTH    8   stream beat width W; masks arrive W bits per beat
//  JOLTAGE_W         10  width of one joltage target (DAY10_JOLTAGE_EN only)
//  derived: NL_W=$clog2(MAX_NUM_LIGHTS+1), NB_W=$clog2(MAX_NUM_BUTTONS+1)
// PORTS
//  clk            in   1                     clock
//  rst            in   1                     async active-high reset
//  data_in        slave axi_stream_if #(AXI_DATA_WIDTH)   tvalid/tready/tdata/tlast
//  out_valid      out  1                     record held on outputs
//  out_ready      in   1                     consumer accepts record
//  num_lights     out  NL_W                  light count of held record
//  target_mask    out  MAX_NUM_LIGHTS        bit i = light i on in target
//  num_buttons    out  NB_W                  button count of held record
//  buttons        out  [MAX_NUM_BUTTONS][MAX_NUM_LIGHTS]  bit i = button toggles light i
//  joltage        out  [MAX_NUM_LIGHTS][JOLTAGE_W]        (DAY10_JOLTAGE_EN only)
//  record_count   out  16                    records handed off, wraps at 2^16
//  end_of_input   out  1                     sticky: beat with tlast accepted
//  err_overflow   out  1                     sticky: count exceeded MAX_*
//  err_framing    out  1                     sticky: tlast before record complete
// BEHAVIOUR
//  Reset: state=S_LCNT. All outputs are 0: out_valid, fields, record_count, flags.
//  Stream format: 1 beat light count; VB=ceil(num_lights/W) beats target mask, LSB-first;
//   1 beat button count; num_buttons x VB beats button masks, LSB-first; [joltages].
//  Count beats use tdata[NL_W-1:0] and tdata[NB_W-1:0]. Higher bits are ignored.
//  FSM: S_LCNT -> S_TGT -> S_BCNT -> S_BTN -> (S_JOLT) -> S_OUT -> S_LCNT.
//  Each state leaves only on its final accepted beat (tvalid&&tready).
//  tready=1 in every read state and 0 in S_OUT. out_valid=1 exactly while in S_OUT.
//  Latency: out_valid rises the cycle after the final beat is accepted.
//  On out_valid&&out_ready: record_count+1. The next beat can be accepted one cycle later.
//  Fields stay stable while out_valid=1. On accept of a light-count beat, target_mask,
//   buttons and joltage clear to 0, so unused entries always read 0.
//  Beat counter runs 0..VB-1 per vector; button index 0..num_buttons-1. Mask bits at
//   position >= num_lights are dropped to 0.
//  num_lights=0: VB=0. S_TGT and each button vector take 0 beats (all-zero masks).
//  num_buttons=0: S_BTN skipped.
//  Count > MAX: set err_overflow and saturate the stored field to MAX.
//   The reader still consumes the declared number of beats and discards extra data.
//  tlast on the final beat of a record: normal. Set end_of_input and hand off the record.
//  tlast on any other beat: set err_framing and end_of_input, discard the record (no
//   out_valid), and go to S_LCNT.
//  end_of_input does not block parsing. The flags clear only on rst.
//  Async rst mid-record or mid-handoff: immediately return to the reset state.
//   The partial record is lost.
// CONFIGURATION
//  DAY10_JOLTAGE_EN defined: S_JOLT follows S_BTN. It takes num_lights beats; beat k
//   stores tdata[JOLTAGE_W-1:0] into joltage[k]. The joltage port exists.
//  Not defined: S_BTN goes straight to S_OUT. No joltage port or storage exists.
// TESTING
//  W=8, stream 4,0x06,2,0x0A,0x05(tlast) -> out_valid: num_lights=4, target=0x6,
//   buttons[0]=0xA, buttons[1]=0x5, end_of_input=1.
//  W=8, lights=12: target beats 0xFF,0xFF -> target_mask=0x0FFF (bits >=12 dropped).
//  Hold out_ready=0 for 20 cycles -> tready=0 and fields stable. Then ready=1 ->
//   record_count=1, next record parsed.
//  button count=20 with MAX=16 -> err_overflow=1, num_buttons=16. Reader consumes 20
//   vectors, and the following record parses correctly.
//  tlast on the 2nd button beat of 3 -> err_framing=1, no out_valid, FSM back in S_LCNT.
//  DAY10_JOLTAGE_EN, lights=3, joltages 3,5,4 -> joltage={4,5,3}. Assert rst mid-S_JOLT
//   -> all outputs 0 next cycle.

Source files
------------

// File: rtl/day10_machine_reader_if.sv
// AXI-stream beat interface feeding the day-10 machine reader.
// Source drives tvalid/tdata/tlast; the reader drives tready.
interface axi_stream_if #(
  parameter int W = 8
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (
    output tvalid, tdata, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast,
    output tready
  );
endinterface

// File: rtl/day10_machine_reader.sv
// Day-10 machine record parser: stream beats into registered fields.
// Optional joltage section enabled by defining DAY10_JOLTAGE_EN.
module day10_machine_reader #(
  parameter int MAX_NUM_LIGHTS  = 16,
  parameter int MAX_NUM_BUTTONS = 16,
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int JOLTAGE_W       = 10,
  localparam int NL_W = $clog2(MAX_NUM_LIGHTS + 1),
  localparam int NB_W = $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic clk,
  input  logic rst,
  axi_stream_if.slave data_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [NL_W-1:0] num_lights,
  output logic [MAX_NUM_LIGHTS-1:0] target_mask,
  output logic [NB_W-1:0] num_buttons,
  output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons,
`ifdef DAY10_JOLTAGE_EN
  output logic [MAX_NUM_LIGHTS-1:0][JOLTAGE_W-1:0] joltage,
`endif
  output logic [15:0] record_count,
  output logic end_of_input,
  output logic err_overflow,
  output logic err_framing
);

  localparam int EXT_W = MAX_NUM_LIGHTS + AXI_DATA_WIDTH;
  localparam logic [NL_W-1:0] NL_ONE = NL_W'(1);
  localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);

  typedef enum logic [2:0] {
    S_LCNT, S_TGT, S_BCNT, S_BTN, S_JOLT, S_OUT
  } state_t;

  state_t state, next_state, nxt, after_btn;

  // Raw declared counts drive beat consumption even when saturated.
  logic [NL_W-1:0] lcnt_raw, vb, beat_cnt;
  logic [NB_W-1:0] bcnt_raw, btn_idx;
  logic [NL_W-1:0] lraw_d, vb_d;
  logic [NB_W-1:0] bcnt_d;
  logic acc, rec_done, framing;
  logic beat_last, btn_last, jolt_last;
  logic [EXT_W-1:0] ext;
  logic [MAX_NUM_LIGHTS-1:0] lmask, beat_bits;

`ifdef DAY10_JOLTAGE_EN
  logic [JOLTAGE_W+AXI_DATA_WIDTH-1:0] jext;
  assign jext = {JOLTAGE_W'(0), data_in.tdata};
`endif

  assign out_valid      = (state == S_OUT);
  assign data_in.tready = (state != S_OUT);
  assign acc            = data_in.tvalid && data_in.tready;

  assign lraw_d = data_in.tdata[NL_W-1:0];
  assign bcnt_d = data_in.tdata[NB_W-1:0];
  assign vb_d   = NL_W'((32'(lraw_d) + AXI_DATA_WIDTH - 1)
                        / AXI_DATA_WIDTH);

  assign beat_last = (beat_cnt + NL_ONE == vb);
  assign btn_last  = (btn_idx + NB_ONE == bcnt_raw);
  assign jolt_last = (beat_cnt + NL_ONE == lcnt_raw);

  always_comb begin
    ext = EXT_W'(data_in.tdata) << (32'(beat_cnt) * AXI_DATA_WIDTH);
    for (int i = 0; i < MAX_NUM_LIGHTS; i++) begin
      lmask[i] = (i < int'(lcnt_raw));
    end
    beat_bits = ext[MAX_NUM_LIGHTS-1:0] & lmask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LCNT;
    else     state <= next_state;
  end

  always_comb begin
    after_btn = S_OUT;
`ifdef DAY10_JOLTAGE_EN
    if (lcnt_raw != '0) after_btn = S_JOLT;
`endif
    nxt = state;
    unique case (state)
      S_LCNT: nxt = (vb_d == '0) ? S_BCNT : S_TGT;
      S_TGT:  if (beat_last) nxt = S_BCNT;
      S_BCNT: nxt = (bcnt_d == '0 || vb == '0) ? after_btn : S_BTN;
      S_BTN:  if (beat_last && btn_last) nxt = after_btn;
      S_JOLT: if (jolt_last) nxt = S_OUT;
      default: nxt = state;
    endcase
    rec_done = (state != S_OUT) && (nxt == S_OUT);
    framing  = acc && data_in.tlast && !rec_done;
    next_state = state;
    if (state == S_OUT) begin
      if (out_ready) next_state = S_LCNT;
    end else if (acc) begin
      next_state = framing ? S_LCNT : nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt_raw    <= '0;
      vb          <= '0;
      beat_cnt    <= '0;
      bcnt_raw    <= '0;
      btn_idx     <= '0;
      num_lights  <= '0;
      num_buttons <= '0;
      target_mask <= '0;
      buttons     <= '0;
`ifdef DAY10_JOLTAGE_EN
      joltage     <= '0;
`endif
    end else if (acc) begin
      unique case (state)
        S_LCNT: begin
          lcnt_raw    <= lraw_d;
          vb          <= vb_d;
          beat_cnt    <= '0;
          btn_idx     <= '0;
          target_mask <= '0;
          buttons     <= '0;
`ifdef DAY10_JOLTAGE_EN
          joltage     <= '0;
`endif
          num_lights  <= (32'(lraw_d) > MAX_NUM_LIGHTS)
                         ? NL_W'(MAX_NUM_LIGHTS) : lraw_d;
        end
        S_TGT: begin
          target_mask <= target_mask | beat_bits;
          beat_cnt    <= beat_last ? '0 : beat_cnt + NL_ONE;
        end
        S_BCNT: begin
          bcnt_raw    <= bcnt_d;
          beat_cnt    <= '0;
          btn_idx     <= '0;
          num_buttons <= (32'(bcnt_d) > MAX_NUM_BUTTONS)
                         ? NB_W'(MAX_NUM_BUTTONS) : bcnt_d;
        end
        S_BTN: begin
          for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
            if (NB_W'(b) == btn_idx) begin
              buttons[b] <= buttons[b] | beat_bits;
            end
          end
          if (beat_last) begin
            beat_cnt <= '0;
            btn_idx  <= btn_idx + NB_ONE;
          end else begin
            beat_cnt <= beat_cnt + NL_ONE;
          end
        end
`ifdef DAY10_JOLTAGE_EN
        S_JOLT: begin
          for (int k = 0; k < MAX_NUM_LIGHTS; k++) begin
            if (NL_W'(k) == beat_cnt) begin
              joltage[k] <= jext[JOLTAGE_W-1:0];
            end
          end
          beat_cnt <= beat_cnt + NL_ONE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      record_count <= '0;
      end_of_input <= 1'b0;
      err_overflow <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      if (out_valid && out_ready) record_count <= record_count + 16'd1;
      if (acc && data_in.tlast) end_of_input <= 1'b1;
      if (framing) err_framing <= 1'b1;
      if (acc && state == S_LCNT && 32'(lraw_d) > MAX_NUM_LIGHTS)
        err_overflow <= 1'b1;
      if (acc && state == S_BCNT && 32'(bcnt_d) > MAX_NUM_BUTTONS)
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_day10_machine_reader.sv
// Bench for day10_machine_reader: directed table, corner sequences
// and randomized records against a field-level model.
module tb_day10_machine_reader;
  localparam int ML = 16;
  localparam int MB = 16;
  localparam int W  = 8;
  localparam int JW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stream_if #(.W(W)) s ();
  logic out_valid, out_ready;
  logic [4:0] num_lights, num_buttons;
  logic [ML-1:0] target_mask;
  logic [MB-1:0][ML-1:0] buttons;
  logic [15:0] record_count;
  logic end_of_input, err_overflow, err_framing;
`ifdef DAY10_JOLTAGE_EN
  logic [ML-1:0][JW-1:0] joltage;
`endif

  day10_machine_reader #(
    .MAX_NUM_LIGHTS(ML), .MAX_NUM_BUTTONS(MB),
    .AXI_DATA_WIDTH(W), .JOLTAGE_W(JW)
  ) dut (
    .clk(clk), .rst(rst), .data_in(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .num_lights(num_lights), .target_mask(target_mask),
    .num_buttons(num_buttons), .buttons(buttons),
`ifdef DAY10_JOLTAGE_EN
    .joltage(joltage),
`endif
    .record_count(record_count), .end_of_input(end_of_input),
    .err_overflow(err_overflow), .err_framing(err_framing)
  );

  int tests = 0;
  int fails = 0;
  bit [31:0] bv[32];
  bit [7:0]  jv[32];
  int exp_rc = 0;
  bit exp_ovf = 0, exp_eoi = 0, exp_frm = 0;

  typedef struct {
    int nl; int nb; bit [2:0] hi;
    bit [31:0] tgt; bit [31:0] b0; bit [31:0] b1;
    int e_nl; int e_nb;
    bit [15:0] e_tgt; bit [15:0] e_b0; bit [15:0] e_b1;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input bit [7:0] d, input bit l);
    int n;
    n = 0;
    if ($urandom_range(3) == 0) repeat ($urandom_range(2)) @(negedge clk);
    @(negedge clk);
    s.tvalid = 1'b1; s.tdata = d; s.tlast = l;
    while (s.tready !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("tready_timeout", s.tready, 1);
    @(posedge clk); #1;
    s.tvalid = 1'b0; s.tlast = 1'b0;
  endtask

  // tl_at: -1 no tlast, -2 tlast on final beat, else beat index (truncates)
  task automatic send_record(input int nl, input int nb,
                             input bit [31:0] tgt, input int tl_at,
                             input bit [2:0] hi);
    bit [8:0] q[$];
    int vb;
    bit [4:0] c;
    vb = (nl + 7) / 8;
    c = nl[4:0]; q.push_back({1'b0, hi, c});
    for (int b = 0; b < vb; b++) q.push_back({1'b0, tgt[8*b +: 8]});
    c = nb[4:0]; q.push_back({1'b0, hi, c});
    for (int i = 0; i < nb; i++)
      for (int b = 0; b < vb; b++) q.push_back({1'b0, bv[i][8*b +: 8]});
`ifdef DAY10_JOLTAGE_EN
    for (int k = 0; k < nl; k++) q.push_back({1'b0, jv[k]});
`endif
    if (tl_at == -2) q[q.size()-1][8] = 1'b1;
    else if (tl_at >= 0) begin
      q[tl_at][8] = 1'b1;
      while (q.size() > tl_at + 1) void'(q.pop_back());
      exp_frm = 1'b1;
    end
    if (tl_at != -1) exp_eoi = 1'b1;
    if (nl > ML || nb > MB) exp_ovf = 1'b1;
    foreach (q[i]) send_beat(q[i][7:0], q[i][8]);
  endtask

  task automatic handoff(input int hold, input bit [15:0] etgt);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_tready", s.tready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_target", target_mask, etgt);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    exp_rc++;
    chk("record_count", record_count, 16'(exp_rc));
    chk("valid_drop", out_valid, 0);
    chk("tready_back", s.tready, 1);
  endtask

  task automatic check_flags();
    chk("err_overflow", err_overflow, exp_ovf);
    chk("end_of_input", end_of_input, exp_eoi);
    chk("err_framing", err_framing, exp_frm);
  endtask

  task automatic check_record(input int nl, input int nb,
                              input bit [31:0] tgt, input int hold);
    int enl, enb;
    bit [15:0] m;
    enl = (nl > ML) ? ML : nl;
    enb = (nb > MB) ? MB : nb;
    m = (enl == 16) ? 16'hFFFF : 16'((32'd1 << enl) - 1);
    chk("latency_valid", out_valid, 1);
    chk("tready_out", s.tready, 0);
    chk("num_lights", num_lights, enl);
    chk("num_buttons", num_buttons, enb);
    chk("target_mask", target_mask, tgt[15:0] & m);
    for (int i = 0; i < MB; i++)
      chk($sformatf("button%0d", i), buttons[i],
          (i < enb) ? (bv[i][15:0] & m) : 16'h0);
`ifdef DAY10_JOLTAGE_EN
    for (int k = 0; k < ML; k++)
      chk($sformatf("joltage%0d", k), joltage[k],
          (k < enl) ? {2'b00, jv[k]} : 10'h0);
`endif
    check_flags();
    handoff(hold, tgt[15:0] & m);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_tready"}, s.tready, 1);
    chk({tag, "_lights"}, num_lights, 0);
    chk({tag, "_nbtn"}, num_buttons, 0);
    chk({tag, "_target"}, target_mask, 0);
    chk({tag, "_buttons"}, |buttons, 0);
`ifdef DAY10_JOLTAGE_EN
    chk({tag, "_joltage"}, |joltage, 0);
`endif
    chk({tag, "_count"}, record_count, 0);
    chk({tag, "_flags"}, {end_of_input, err_overflow, err_framing}, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; #1;
    exp_rc = 0; exp_ovf = 0; exp_eoi = 0; exp_frm = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nb, hold;
    bit [31:0] tgt;
    rst = 1'b1; out_ready = 1'b0;
    s.tvalid = 1'b0; s.tdata = '0; s.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst = 1'b0;

    tbl[0] = '{4, 2, 3'd0, 32'h06, 32'h0A, 32'h05,
               4, 2, 16'h0006, 16'h000A, 16'h0005};
    tbl[1] = '{12, 2, 3'd7, 32'hFFFF, 32'h1234, 32'hF00F,
               12, 2, 16'h0FFF, 16'h0234, 16'h000F};
    tbl[2] = '{0, 2, 3'd0, 32'h0, 32'hFF, 32'hFF,
               0, 2, 16'h0, 16'h0, 16'h0};
    tbl[3] = '{16, 1, 3'd2, 32'hBEEF, 32'h8001, 32'h7777,
               16, 1, 16'hBEEF, 16'h8001, 16'h0};
    tbl[4] = '{3, 0, 3'd5, 32'hFD, 32'h0, 32'h0,
               3, 0, 16'h0005, 16'h0, 16'h0};
    tbl[5] = '{20, 2, 3'd0, 32'hABCDEF, 32'h00FFFF, 32'h123456,
               16, 2, 16'hCDEF, 16'hFFFF, 16'h3456};

    for (int t = 0; t < 6; t++) begin
      bv[0] = tbl[t].b0; bv[1] = tbl[t].b1;
      for (int k = 0; k < 32; k++) jv[k] = 8'(k + 1);
      send_record(tbl[t].nl, tbl[t].nb, tbl[t].tgt, -1, tbl[t].hi);
      chk($sformatf("t%0d_valid", t), out_valid, 1);
      chk($sformatf("t%0d_nl", t), num_lights, tbl[t].e_nl);
      chk($sformatf("t%0d_nb", t), num_buttons, tbl[t].e_nb);
      chk($sformatf("t%0d_tgt", t), target_mask, tbl[t].e_tgt);
      chk($sformatf("t%0d_b0", t), buttons[0], tbl[t].e_b0);
      chk($sformatf("t%0d_b1", t), buttons[1], tbl[t].e_b1);
      chk($sformatf("t%0d_b2", t), buttons[2], 16'h0);
      check_flags();
      handoff(0, tbl[t].e_tgt);
    end

    bv[0] = 32'h0A; bv[1] = 32'h05;
    send_record(4, 2, 32'h06, -2, 3'd0);
    check_record(4, 2, 32'h06, 0);

    for (int i = 0; i < 32; i++) bv[i] = $urandom;
    send_record(5, 3, 32'h15, -1, 3'd0);
    check_record(5, 3, 32'h15, 20);

    send_record(4, 20, 32'h9, -1, 3'd0);
    check_record(4, 20, 32'h9, 1);
    send_record(9, 2, 32'h1A5, -1, 3'd0);
    check_record(9, 2, 32'h1A5, 0);

    send_record(8, 3, 32'h3C, 4, 3'd0);
    chk("frm_valid", out_valid, 0);
    chk("frm_tready", s.tready, 1);
    check_flags();
    repeat (3) @(posedge clk);
    #1;
    chk("frm_valid_later", out_valid, 0);
    chk("frm_count", record_count, 16'(exp_rc));
    send_record(6, 2, 32'h2B, -1, 3'd0);
    check_record(6, 2, 32'h2B, 0);

    for (int r = 0; r < 40; r++) begin
      nl = ($urandom_range(7) == 0) ? $urandom_range(31, 17)
                                    : $urandom_range(16);
      nb = $urandom_range(20);
      tgt = $urandom;
      hold = $urandom_range(3);
      for (int i = 0; i < 32; i++) bv[i] = $urandom;
      for (int k = 0; k < 32; k++) jv[k] = 8'($urandom);
      send_record(nl, nb, tgt, -1, 3'($urandom_range(7)));
      check_record(nl, nb, tgt, hold);
    end

    send_record(4, 2, 32'h6, -1, 3'd0);
    chk("pre_rst_valid", out_valid, 1);
    apply_reset();
    check_reset_state("rst_handoff");
    @(negedge clk); rst = 1'b0;
    send_beat(8'd12, 1'b0);
    send_beat(8'hFF, 1'b0);
    apply_reset();
    check_reset_state("rst_record");
    @(negedge clk); rst = 1'b0;
    send_record(7, 2, 32'h55, -1, 3'd0);
    check_record(7, 2, 32'h55, 0);

`ifdef DAY10_JOLTAGE_EN
    jv[0] = 8'd3; jv[1] = 8'd5; jv[2] = 8'd4;
    send_record(3, 0, 32'h5, -1, 3'd0);
    chk("jolt0", joltage[0], 10'd3);
    chk("jolt1", joltage[1], 10'd5);
    chk("jolt2", joltage[2], 10'd4);
    chk("jolt3", joltage[3], 10'd0);
    handoff(0, 16'h5);
    send_beat(8'd3, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd0, 1'b0);
    send_beat(8'd3, 1'b0);
    apply_reset();
    check_reset_state("rst_jolt");
    @(negedge clk); rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
